alu_seq_top: RTL and testbench
==============================

ALU_SEQ_TOP -- requirements
Module: alu_seq_top

Interface
REQ-001 SHALL have parameter WIDTH, default 8, operand width in bits (legal range 4..32).
REQ-002 SHALL have port clk, input, 1, sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-004 SHALL have port in_a, input, WIDTH, operand A data.
REQ-005 SHALL have port in_b, input, WIDTH, operand B data.
REQ-006 SHALL have port load_a, input, 1, level; while high at an edge, register A <= in_a.
REQ-007 SHALL have port load_b, input, 1, level; while high at an edge, register B <= in_b.
REQ-008 SHALL have port op, input, 2, 00 add, 01 sub, 10 mul, 11 div; sampled only with start.
REQ-009 SHALL have port start, input, 1, operation request; sampled only in IDLE.
REQ-010 SHALL have port busy, output, 1, high whenever state is not IDLE.
REQ-011 SHALL have port done, output, 1, one-cycle pulse marking result/flag update.
REQ-012 SHALL have port result, output, 2*WIDTH, last completed result, held until next done.
REQ-013 SHALL have port flag, output, 1, carry/borrow/overflow/div-by-zero of last result, held with result.

Function
REQ-014 SHALL implement FSM states IDLE, CALC, DONE; DONE lasts exactly one cycle then returns to IDLE.
REQ-015 SHALL, on start=1 in IDLE, latch op, A and B (values before that edge) into working registers.
REQ-016 SHALL ignore start in CALC and DONE; no queuing.
REQ-017 SHALL ignore load_a/load_b while busy=1; in IDLE, load at the same edge as start updates A/B but the started operation uses the pre-edge values.
REQ-018 SHALL, for add, sub and div with B=0, go IDLE->DONE; done=1 in the cycle after the start edge.
REQ-019 SHALL, for mul and div with B!=0, go IDLE->CALC, stay WIDTH cycles (one bit per cycle via an iteration counter), then DONE; done=1 exactly WIDTH+1 cycles after the start edge.
REQ-020 SHALL compute add: result = zero-extended A+B (carry in bit WIDTH); flag = carry out.
REQ-021 SHALL compute sub: result[WIDTH-1:0] = A-B mod 2^WIDTH, upper bits 0; flag = 1 iff A<B (borrow).
REQ-022 SHALL compute mul: unsigned shift-add, result = A*B full 2*WIDTH; flag = 1 iff result[2W-1:W] != 0.
REQ-023 SHALL compute div: unsigned restoring division, result[W-1:0] = quotient, result[2W-1:W] = remainder; flag = 0.
REQ-024 SHALL, for div with B=0, give result = 0 and flag = 1.
REQ-025 SHALL update result and flag only at the edge entering DONE; intermediate datapath values never appear on result.
REQ-026 SHALL allow start in the IDLE cycle immediately following DONE (back-to-back throughput: 2 cycles add/sub, WIDTH+2 cycles mul/div).
REQ-027 SHALL treat all operands as unsigned; op is don't-care when no start.

Reset
REQ-028 SHALL, while rst=1, force state IDLE, A=0, B=0, working registers and counter 0, result=0, flag=0, busy=0, done=0, independent of clk.
REQ-029 SHALL abort any CALC operation on rst with no done pulse and no result update; first start after rst release is honoured normally.

Verification (WIDTH=8)
REQ-030 SHALL cover add: load A=200, B=100, start op=00 -> done 1 cycle later, result=0x012C, flag=1.
REQ-031 SHALL cover sub: A=5, B=9, op=01 -> result=0x00FC, flag=1; then A=9, B=5 -> 0x0004, flag=0.
REQ-032 SHALL cover mul: A=255, B=255, op=10 -> busy 9 cycles, done exactly 9 cycles after start edge, result=0xFE01, flag=1; A=15, B=17 -> 0x00FF, flag=0.
REQ-033 SHALL cover div: A=200, B=7, op=11 -> result=0x041C (q=28, r=4), flag=0; B=0 -> result=0x0000, flag=1, done after 1 cycle.
REQ-034 SHALL cover interference: start and load_a pulsed during CALC -> ignored, result matches original operands; start+load_a same IDLE edge -> operation uses old A.
REQ-035 SHALL cover reset mid-mul: assert rst at CALC cycle 4 -> busy=0, done never pulses, result=0; new add 1+1 after release -> 0x0002.

Source files
------------

// File: rtl/alu_seq_top.sv
// alu_seq_top -- sequential unsigned ALU with registered operands.
//
// Operands are held in registers A and B, written from in_a / in_b by the
// level-sensitive load_a / load_b strobes while the unit is idle. A start
// request in IDLE snapshots op, A and B into working registers.
//
// Add, sub and divide-by-zero finish in one cycle. Multiply (shift-add) and
// divide (restoring) take WIDTH iterations, one bit per cycle. Results are
// written to result/flag only on the edge that enters DONE.
//
// State table:
//   IDLE | waiting for start; operand loads accepted
//   CALC | iterating mul/div; one bit per cycle, cnt counts down to 1
//   DONE | one-cycle done pulse; result/flag just updated
//
// Ports:
//   clk, rst        rising-edge clock, asynchronous active-high reset
//   in_a, in_b      operand data (WIDTH bits)
//   load_a, load_b  load A/B from in_a/in_b at the edge (IDLE only)
//   op              00 add, 01 sub, 10 mul, 11 div (sampled with start)
//   start           operation request (sampled in IDLE only)
//   busy            high whenever not IDLE
//   done            one-cycle pulse when result/flag update
//   result          last completed result (2*WIDTH bits)
//   flag            carry / borrow / mul overflow / divide-by-zero
module alu_seq_top #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [WIDTH-1:0]     in_a,
  input  logic [WIDTH-1:0]     in_b,
  input  logic                 load_a,
  input  logic                 load_b,
  input  logic [1:0]           op,
  input  logic                 start,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   result,
  output logic                 flag
);

  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_DIV = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_CALC = 2'b01,
    S_DONE = 2'b10
  } state_t;

  state_t state, state_nxt;

  logic [WIDTH-1:0]   a_reg, b_reg;
  logic [1:0]         op_w;
  logic [2*WIDTH-1:0] wa;    // multiplicand, shifted left each mul step
  logic [WIDTH-1:0]   wb;    // multiplier (shifted right) or divisor
  logic [2*WIDTH-1:0] acc;   // mul: partial product; div: {remainder, quotient}
  logic [CW-1:0]      cnt;

  logic multi_cycle;
  logic [WIDTH:0]     sum_ab;
  logic [WIDTH:0]     dif_ab;
  logic [2*WIDTH-1:0] quick_res;
  logic               quick_flag;

  logic [2*WIDTH-1:0] mul_acc_nxt;
  logic [WIDTH:0]     rem_sh;
  logic               div_ge;
  logic [WIDTH-1:0]   rem_nxt;
  logic [2*WIDTH-1:0] div_acc_nxt;
  logic [2*WIDTH-1:0] iter_acc;
  logic               iter_flag;

  // Only mul and a real divide need the iterative path.
  assign multi_cycle = (op == OP_MUL) || ((op == OP_DIV) && (b_reg != '0));

  // Single-cycle results, computed straight from the operand registers so
  // they are ready at the start edge.
  always_comb begin
    sum_ab     = {1'b0, a_reg} + {1'b0, b_reg};
    dif_ab     = {1'b0, a_reg} - {1'b0, b_reg};
    quick_res  = '0;
    quick_flag = 1'b0;
    case (op)
      OP_ADD: begin
        quick_res  = {{(WIDTH-1){1'b0}}, sum_ab};
        quick_flag = sum_ab[WIDTH];
      end
      OP_SUB: begin
        quick_res  = {{WIDTH{1'b0}}, dif_ab[WIDTH-1:0]};
        quick_flag = dif_ab[WIDTH];   // wraps negative exactly when A < B
      end
      default: begin
        // divide by zero: result forced to zero, flag raised
        quick_res  = '0;
        quick_flag = 1'b1;
      end
    endcase
  end

  // One iteration of shift-add multiply or restoring divide.
  always_comb begin
    mul_acc_nxt = wb[0] ? (acc + wa) : acc;

    // Shift the next dividend bit into the partial remainder and try to
    // subtract the divisor; the remainder always fits back in WIDTH bits.
    rem_sh      = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    div_ge      = (rem_sh >= {1'b0, wb});
    rem_nxt     = div_ge ? (rem_sh[WIDTH-1:0] - wb) : rem_sh[WIDTH-1:0];
    div_acc_nxt = {rem_nxt, acc[WIDTH-2:0], div_ge};

    if (op_w == OP_MUL) begin
      iter_acc  = mul_acc_nxt;
      iter_flag = |mul_acc_nxt[2*WIDTH-1:WIDTH];
    end else begin
      iter_acc  = div_acc_nxt;
      iter_flag = 1'b0;
    end
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (start) begin
          state_nxt = multi_cycle ? S_CALC : S_DONE;
        end
      end
      S_CALC: begin
        if (cnt == CW'(1)) begin
          state_nxt = S_DONE;
        end
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    busy = (state != S_IDLE);
    done = (state == S_DONE);
  end

  // Operand, working and result registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_reg  <= '0;
      b_reg  <= '0;
      op_w   <= '0;
      wa     <= '0;
      wb     <= '0;
      acc    <= '0;
      cnt    <= '0;
      result <= '0;
      flag   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (load_a) a_reg <= in_a;
          if (load_b) b_reg <= in_b;
          if (start) begin
            // Uses pre-edge A/B even if a load lands on the same edge.
            op_w <= op;
            wa   <= {{WIDTH{1'b0}}, a_reg};
            wb   <= b_reg;
            acc  <= (op == OP_DIV) ? {{WIDTH{1'b0}}, a_reg} : '0;
            cnt  <= CW'(WIDTH);
            if (!multi_cycle) begin
              result <= quick_res;
              flag   <= quick_flag;
            end
          end
        end
        S_CALC: begin
          cnt <= cnt - CW'(1);
          acc <= iter_acc;
          if (op_w == OP_MUL) begin
            wa <= wa << 1;
            wb <= wb >> 1;
          end
          if (cnt == CW'(1)) begin
            result <= iter_acc;
            flag   <= iter_flag;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq_top.sv
module tb_alu_seq_top;

  localparam int W = 8;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [W-1:0]   in_a = '0;
  logic [W-1:0]   in_b = '0;
  logic           load_a = 1'b0;
  logic           load_b = 1'b0;
  logic [1:0]     op = '0;
  logic           start = 1'b0;
  logic           busy;
  logic           done;
  logic [2*W-1:0] result;
  logic           flag;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  alu_seq_top #(.WIDTH(W)) dut (
    .clk    (clk),
    .rst    (rst),
    .in_a   (in_a),
    .in_b   (in_b),
    .load_a (load_a),
    .load_b (load_b),
    .op     (op),
    .start  (start),
    .busy   (busy),
    .done   (done),
    .result (result),
    .flag   (flag)
  );

  always #5 clk = ~clk;

  function automatic void chk(string name, longint unsigned act, longint unsigned exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endfunction

  // Behavioural model: plain arithmetic plus a count of remaining busy cycles.
  longint unsigned m_a = 0, m_b = 0, m_res = 0, p_res = 0;
  bit              m_flag = 0, p_flag = 0;
  int              m_left = 0;

  always @(posedge clk or posedge rst) begin
    bit idle;
    if (rst) begin
      m_a = 0; m_b = 0; m_res = 0; m_flag = 0; m_left = 0;
    end else begin
      idle = (m_left == 0);
      if (idle && start) begin
        case (op)
          2'd0: begin p_res = m_a + m_b; p_flag = (p_res >= (64'd1 << W)); end
          2'd1: begin p_res = (m_a - m_b) & ((64'd1 << W) - 1); p_flag = (m_a < m_b); end
          2'd2: begin p_res = m_a * m_b; p_flag = (p_res >= (64'd1 << W)); end
          default: begin
            if (m_b == 0) begin p_res = 0; p_flag = 1; end
            else begin p_res = ((m_a % m_b) << W) | (m_a / m_b); p_flag = 0; end
          end
        endcase
        m_left = (op == 2'd2 || (op == 2'd3 && m_b != 0)) ? W + 1 : 1;
      end else if (!idle) begin
        m_left--;
      end
      if (idle) begin
        if (load_a) m_a = in_a;
        if (load_b) m_b = in_b;
      end
      if (m_left == 1) begin
        m_res  = p_res;
        m_flag = p_flag;
      end
    end
  end

  // Cycle-by-cycle comparison against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("busy", busy, (m_left != 0));
      chk("done", done, (m_left == 1));
      chk("result", result, m_res);
      chk("flag", flag, m_flag);
    end
  end

  task automatic wait_done(string name, int cyc0, longint unsigned er, bit ef, int el);
    int cyc = cyc0;
    while (!done && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    chk({name, "_lat"}, cyc, el);
    chk({name, "_res"}, result, er);
    chk({name, "_flag"}, flag, ef);
    chk({name, "_model"}, m_res, er);
  endtask

  task automatic start_op(string name, logic [1:0] o, bit la, logic [W-1:0] na,
                          longint unsigned er, bit ef, int el);
    @(negedge clk);
    load_a = la; load_b = 1'b0;
    if (la) in_a = na;
    op = o; start = 1'b1;
    @(negedge clk);
    start = 1'b0; load_a = 1'b0;
    wait_done(name, 1, er, ef, el);
  endtask

  task automatic do_op(string name, logic [W-1:0] a, logic [W-1:0] b, logic [1:0] o,
                       longint unsigned er, bit ef, int el);
    @(negedge clk);
    in_a = a; in_b = b; load_a = 1'b1; load_b = 1'b1;
    start_op(name, o, 1'b0, '0, er, ef, el);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk_en = 1'b1;
    chk("rst_busy", busy, 0);
    chk("rst_result", result, 0);
    #2 rst = 1'b0;

    do_op("add", 200, 100, 2'b00, 16'h012C, 1, 1);
    do_op("sub_borrow", 5, 9, 2'b01, 16'h00FC, 1, 1);
    do_op("sub", 9, 5, 2'b01, 16'h0004, 0, 1);
    // back-to-back: start in the IDLE cycle right after DONE
    start_op("b2b_add", 2'b00, 1'b0, '0, 16'h000E, 0, 1);
    do_op("mul_max", 255, 255, 2'b10, 16'hFE01, 1, 9);
    do_op("mul", 15, 17, 2'b10, 16'h00FF, 0, 9);
    do_op("div", 200, 7, 2'b11, 16'h041C, 0, 9);
    do_op("div0", 200, 0, 2'b11, 16'h0000, 1, 1);
    do_op("div_small", 3, 200, 2'b11, 16'h0300, 0, 9);

    // start and load_a during CALC are ignored
    @(negedge clk);
    in_a = 15; in_b = 17; load_a = 1'b1; load_b = 1'b1;
    @(negedge clk);
    load_a = 1'b0; load_b = 1'b0; op = 2'b10; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    in_a = 99; load_a = 1'b1; op = 2'b00; start = 1'b1;
    @(negedge clk);
    load_a = 1'b0; start = 1'b0;
    wait_done("calc_ignore", 3, 16'h00FF, 0, 9);
    start_op("a_kept", 2'b00, 1'b0, '0, 16'h0020, 0, 1);

    // load_a on the start edge: operation uses old A, new A visible next time
    do_op("pre_load", 10, 3, 2'b00, 16'h000D, 0, 1);
    start_op("same_edge", 2'b00, 1'b1, 50, 16'h000D, 0, 1);
    start_op("new_a", 2'b00, 1'b0, '0, 16'h0035, 0, 1);

    // reset in CALC cycle 4 of a multiply
    @(negedge clk);
    in_a = 255; in_b = 255; load_a = 1'b1; load_b = 1'b1;
    @(negedge clk);
    load_a = 1'b0; load_b = 1'b0; op = 2'b10; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    chk("calc4_busy", busy, 1);
    #2 rst = 1'b1;
    #1;
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_done", done, 0);
    chk("rst_mid_result", result, 0);
    repeat (2) @(negedge clk);
    #2 rst = 1'b0;
    repeat (12) begin
      @(negedge clk);
      chk("no_done_after_rst", done, 0);
    end
    chk("rst_result_kept", result, 0);
    do_op("add_after_rst", 1, 1, 2'b00, 16'h0002, 0, 1);

    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
